// File: rtl/alu_iterative.sv
// Execute-stage ALU: single-cycle logic/arith/shift ops plus an iterative shift-add MUL
// that stalls the pipeline via busy_o. Optional macro ALU_MUL_EARLY_TERM_EN ends MUL early.
module alu_iterative #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [2:0]        ALUCtrl_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] data2_i,
  output logic [DATA_W-1:0] result_o,
  output logic              valid_o,
  output logic              busy_o
);

  localparam int CNT_W = SHAMT_W + 1;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_XOR  = 3'b001;
  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_ADDI = 3'b110;
  localparam logic [2:0] OP_SRAI = 3'b111;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  mcand_q, mcand_d;
  logic [DATA_W-1:0]  mplier_q, mplier_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0]  mul_sum;
  logic [DATA_W-1:0]  mplier_shr;
  logic               mul_done;
  logic               mul_skip;

  function automatic logic [DATA_W-1:0] simple_op(input logic [2:0] op,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] a_s;
    logic [DATA_W-1:0]        r;
    a_s = a;
    case (op)
      OP_AND:          r = a & b;
      OP_XOR:          r = a ^ b;
      OP_SLL:          r = a << b[SHAMT_W-1:0];
      OP_ADD, OP_ADDI: r = a + b;
      OP_SUB:          r = a - b;
      OP_SRAI:         r = a_s >>> b[SHAMT_W-1:0];
      default:         r = '0;
    endcase
    return r;
  endfunction

  assign ready_o  = (state_q == S_IDLE);
  assign busy_o   = (state_q == S_MUL);
  assign result_o = result_q;
  assign valid_o  = valid_q;

  assign mplier_shr = mplier_q >> 1;
  assign mul_sum    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

`ifdef ALU_MUL_EARLY_TERM_EN
  // A zero multiplier never enters MUL; otherwise stop once no multiplier bits remain.
  assign mul_skip = (data2_i == '0);
  assign mul_done = (mplier_shr == '0) || (cnt_q == CNT_W'(DATA_W - 1));
`else
  assign mul_skip = 1'b0;
  assign mul_done = (cnt_q == CNT_W'(DATA_W - 1));
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    valid_d  = 1'b0;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          if (ALUCtrl_i != OP_MUL) begin
            result_d = simple_op(ALUCtrl_i, data1_i, data2_i);
            valid_d  = 1'b1;
          end else if (mul_skip) begin
            result_d = '0;
            valid_d  = 1'b1;
          end else begin
            mcand_d  = data1_i;
            mplier_d = data2_i;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_MUL;
          end
        end
      end
      S_MUL: begin
        acc_d    = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_shr;
        cnt_d    = cnt_q + CNT_W'(1);
        if (mul_done) begin
          result_d = mul_sum;
          valid_d  = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
    end
  end

  // Multiplier datapath is only meaningful inside MUL, so it carries no reset.
  always_ff @(posedge clk_i) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    acc_q    <= acc_d;
  end

endmodule

// File: tb/tb_alu_iterative.sv
// Directed bench for alu_iterative; expected MUL latencies follow ALU_MUL_EARLY_TERM_EN.
module tb_alu_iterative;
  localparam int W = 32;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_XOR  = 3'b001;
  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_ADDI = 3'b110;
  localparam logic [2:0] OP_SRAI = 3'b111;

`ifdef ALU_MUL_EARLY_TERM_EN
  localparam int CYC_67 = 3;
  localparam int CYC_35 = 3;
  localparam int CYC_23 = 2;
  localparam int CYC_90 = 0;
`else
  localparam int CYC_67 = 32;
  localparam int CYC_35 = 32;
  localparam int CYC_23 = 32;
  localparam int CYC_90 = 32;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_i;
  logic         ready_o;
  logic [2:0]   alu_ctrl;
  logic [W-1:0] data1, data2;
  logic [W-1:0] result_o;
  logic         valid_o;
  logic         busy_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_iterative #(.DATA_W(W), .SHAMT_W(5)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .ALUCtrl_i(alu_ctrl),
    .data1_i  (data1),
    .data2_i  (data2),
    .result_o (result_o),
    .valid_o  (valid_o),
    .busy_o   (busy_o)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    valid_i  = v;
    alu_ctrl = op;
    data1    = a;
    data2    = b;
  endtask

  // Issues one MUL, watches the busy window, then checks the completion pulse.
  task automatic run_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_res, input int exp_cyc,
                         input logic [W-1:0] prev_res);
    int n;
    drive(1'b1, OP_MUL, a, b);
    tick;
    drive(1'b0, OP_ADD, 32'hDEAD_BEEF, 32'h1234_5678);
    n = 0;
    while (busy_o && n < 100) begin
      check({tag, "_ready_low"}, W'(ready_o), W'(0));
      check({tag, "_valid_low"}, W'(valid_o), W'(0));
      check({tag, "_result_hold"}, result_o, prev_res);
      n++;
      tick;
    end
    check({tag, "_busy_cycles"}, W'(n), W'(exp_cyc));
    check({tag, "_valid"}, W'(valid_o), W'(1));
    check({tag, "_result"}, result_o, exp_res);
    check({tag, "_ready"}, W'(ready_o), W'(1));
    tick;
    check({tag, "_valid_drop"}, W'(valid_o), W'(0));
  endtask

  initial begin
    int n;
    rst = 1'b1;
    drive(1'b0, OP_AND, '0, '0);
    tick;
    tick;
    check("rst_result", result_o, 32'h0);
    check("rst_valid", W'(valid_o), W'(0));
    check("rst_busy", W'(busy_o), W'(0));
    check("rst_ready", W'(ready_o), W'(1));
    rst = 1'b0;

    // Back-to-back ADD then SUB
    drive(1'b1, OP_ADD, 32'd5, 32'd7);
    tick;
    check("add_valid", W'(valid_o), W'(1));
    check("add_result", result_o, 32'h0000_000C);
    check("add_ready", W'(ready_o), W'(1));
    drive(1'b1, OP_SUB, 32'd3, 32'd5);
    tick;
    check("sub_valid", W'(valid_o), W'(1));
    check("sub_result", result_o, 32'hFFFF_FFFE);
    check("sub_ready", W'(ready_o), W'(1));
    drive(1'b1, OP_SRAI, 32'h8000_0000, 32'd4);
    tick;
    check("srai_valid", W'(valid_o), W'(1));
    check("srai_result", result_o, 32'hF800_0000);
    drive(1'b1, OP_SLL, 32'h1, 32'd31);
    tick;
    check("sll_result", result_o, 32'h8000_0000);
    drive(1'b1, OP_XOR, 32'hF0F0, 32'hFFFF);
    tick;
    check("xor_result", result_o, 32'h0000_0F0F);
    drive(1'b1, OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0);
    tick;
    check("and_result", result_o, 32'h0F00_0F00);
    // Shift amount uses only the low 5 bits of data2
    drive(1'b1, OP_ADDI, 32'h7FFF_FFFF, 32'h1);
    tick;
    check("addi_wrap", result_o, 32'h8000_0000);
    drive(1'b1, OP_SLL, 32'h3, 32'h0000_0021);
    tick;
    check("sll_mask", result_o, 32'h0000_0006);
    drive(1'b0, OP_ADD, '0, '0);
    tick;
    check("idle_valid_low", W'(valid_o), W'(0));
    check("idle_result_hold", result_o, 32'h0000_0006);

    run_mul("mul_6x7", 32'd6, 32'd7, 32'd42, CYC_67, 32'h0000_0006);
    run_mul("mul_m3x5", 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, CYC_35, 32'd42);

    // ADD held on valid_i throughout a MUL
    drive(1'b1, OP_MUL, 32'd2, 32'd3);
    tick;
    drive(1'b1, OP_ADD, 32'd10, 32'd20);
    n = 0;
    while (busy_o && n < 100) begin
      check("hold_valid_low", W'(valid_o), W'(0));
      check("hold_result_hold", result_o, 32'hFFFF_FFF1);
      n++;
      tick;
    end
    check("hold_busy_cycles", W'(n), W'(CYC_23));
    check("hold_mul_valid", W'(valid_o), W'(1));
    check("hold_mul_result", result_o, 32'd6);
    tick;
    check("hold_add_valid", W'(valid_o), W'(1));
    check("hold_add_result", result_o, 32'd30);
    drive(1'b0, OP_ADD, '0, '0);
    tick;
    check("hold_valid_drop", W'(valid_o), W'(0));
    check("hold_result_keep", result_o, 32'd30);

    // Reset in the middle of a long MUL
    drive(1'b1, OP_MUL, 32'd3, 32'hFFFF_FFFF);
    tick;
    drive(1'b0, OP_ADD, '0, '0);
    repeat (10) tick;
    check("mid_busy", W'(busy_o), W'(1));
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("abort_ready", W'(ready_o), W'(1));
    check("abort_busy", W'(busy_o), W'(0));
    check("abort_result", result_o, 32'h0);
    check("abort_valid", W'(valid_o), W'(0));
    n = 0;
    for (int i = 0; i < 35; i++) begin
      tick;
      if (valid_o) n++;
    end
    check("abort_no_pulse", W'(n), W'(0));
    drive(1'b1, OP_ADD, 32'd1, 32'd1);
    tick;
    check("post_add_valid", W'(valid_o), W'(1));
    check("post_add_result", result_o, 32'd2);
    drive(1'b0, OP_ADD, '0, '0);
    tick;

    run_mul("mul_9x0", 32'd9, 32'd0, 32'd0, CYC_90, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_iterative.md
Name: alu_iterative

Overview:
- Execute-stage ALU that consumes the 3-bit ALU control code produced by the ALU control decoder, plus the two operands from the ID/EX register.
- Simple ops complete in 1 cycle.
- MUL uses an iterative shift-add datapath over multiple cycles and asserts busy_o to the hazard unit so the pipeline stalls.
- The result goes to the EX/MEM register under a one-cycle valid pulse.

Parameters:
- DATA_W, 32, operand/result width in bits; power of two, at least 8.
- SHAMT_W, 5, shift-amount bits taken from data2_i; equals log2(DATA_W).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- valid_i  input  1  operation request this cycle.
- ready_o  output  1  block can accept a request; high iff state is IDLE.
- ALUCtrl_i  input  3  000 AND, 001 XOR, 010 SLL, 011 ADD, 100 SUB, 101 MUL, 110 ADDI, 111 SRAI.
- data1_i  input  DATA_W  operand rs1.
- data2_i  input  DATA_W  operand rs2 or sign-extended immediate.
- result_o  output  DATA_W  registered result; holds its value between completions.
- valid_o  output  1  one-cycle pulse when result_o is newly updated.
- busy_o  output  1  high while a MUL is in flight (state MUL); drives the stall.

Behaviour:
- Reset (synchronous, rst_i=1 at a clock edge): state=IDLE, result_o=0, valid_o=0, busy_o=0, ready_o=1, iteration counter=0.
- Reset mid-MUL aborts the operation with no valid_o pulse; partial product discarded.
- Accept: occurs at an edge where valid_i=1 and ready_o=1. valid_i while ready_o=0 is ignored; no queueing. The requester must hold or re-present the request.
- States: IDLE and MUL only.
- IDLE, accepted non-MUL code: result_o is loaded at the accept edge and valid_o=1 in the following cycle. Latency is 1. State stays IDLE, so back-to-back accepts give consecutive valid_o pulses.
- IDLE, accepted MUL: latch mcand=data1_i, mplier=data2_i, acc=0, cnt=0; go to MUL; busy_o=1 and ready_o=0 from the next cycle.
- MUL, each edge:
  - if mplier[0], acc += mcand (mod 2^DATA_W)
  - mcand <<= 1; mplier >>= 1 (logical); cnt++
  - on the edge completing iteration DATA_W: result_o = updated acc, valid_o pulses the next cycle, state returns to IDLE.
  - busy_o is high for exactly DATA_W cycles.
  - A new request can be accepted in the same cycle valid_o is high.
- Arithmetic rules:
  - ADD/ADDI and SUB wrap mod 2^DATA_W; no flags.
  - SLL shifts data1_i left by data2_i[SHAMT_W-1:0].
  - SRAI arithmetic-shifts data1_i right by data2_i[SHAMT_W-1:0], replicating the MSB.
  - AND and XOR are bitwise.
  - MUL returns the low DATA_W bits of the product; identical for signed and unsigned operands.
- Operand inputs are sampled only at the accept edge; changes during MUL have no effect.
- valid_o is never high for two consecutive cycles from the same operation.

Optional Feature:
ALU_MUL_EARLY_TERM_EN
- Defined:
  - MUL finishes on the first iteration edge where the shifted mplier becomes 0; latency = floor(log2(data2_i))+1 cycles.
  - data2_i=0 completes like a 1-cycle op: result 0, no MUL state, busy_o stays 0.
  - busy_o covers only the cycles actually spent in MUL.
- Undefined: MUL always runs exactly DATA_W iterations, regardless of operand values.

Test Plan:
- ADD 5+7; SUB 3-5 (DATA_W=32), accepted back-to-back -> result_o=0x0000000C with valid_o in cycle 1, then 0xFFFFFFFE in cycle 2; ready_o stays 1 throughout.
- SRAI 0x80000000 by 4; SLL 0x1 by 31; XOR 0xF0F0,0xFFFF -> 0xF8000000, 0x80000000, 0x0F0F respectively, each with latency 1.
- MUL 6*7 (macro off) -> busy_o high 32 cycles, ready_o low 32 cycles, result_o=42 with valid_o the cycle after the 32nd iteration. MUL -3*5 -> 0xFFFFFFF1.
- ADD request held on valid_i while MUL is busy -> ignored until ready_o=1, then accepted; exactly one valid_o per operation; result_o unchanged during busy.
- rst_i pulsed at MUL iteration 10 -> no valid_o; next cycle ready_o=1, busy_o=0, result_o=0. A subsequent ADD 1+1 yields 2.
- Macro on: MUL 6*7 -> result 42, latency 3, busy_o high 3 cycles. MUL 9*0 -> result 0, latency 1, busy_o never high.
